// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin arbiter sequencing two requesters onto one shared fp32 a-b datapath (optional FPU_ARB_NAN_CHECK_EN)
module fpu_addsub_arbiter #(
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_op,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_op,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  output logic [31:0]     dp_a,
  output logic [31:0]     dp_b,
  input  logic [31:0]     dp_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     rsp_data,
  output logic            rsp_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q;
  logic [31:0]       a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       rsp_data_q;

  logic              gnt0, gnt1;
  logic              accept;
  logic              sel_op;
  logic [31:0]       sel_a, sel_b;
  logic [31:0]       res_data;

  // A lone valid always wins; on contention the priority pointer decides.
  assign gnt0   = req0_valid && (!req1_valid || !prio_q);
  assign gnt1   = req1_valid && (!req0_valid ||  prio_q);
  assign accept = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  assign sel_op = gnt1 ? req1_op : req0_op;
  assign sel_a  = gnt1 ? req1_a  : req0_a;
  assign sel_b  = gnt1 ? req1_b  : req0_b;

  // The datapath only subtracts, so an add is folded into a sign flip of b.
  assign dp_a     = a_q;
  assign dp_b     = b_q;
  assign rsp_id   = id_q;
  assign rsp_data = rsp_data_q;

`ifdef FPU_ARB_NAN_CHECK_EN
  logic rsp_err_q;
  logic operand_special;

  assign operand_special = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
  assign res_data        = operand_special ? 32'h7FC0_0000 : dp_result;
  assign rsp_err         = rsp_err_q;

  // Error flag captured alongside the result at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      rsp_err_q <= operand_special;
    end
  end
`else
  assign res_data = dp_result;
  assign rsp_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; readies only ever raised in IDLE.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand/ID latch on accept; priority moves to the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      id_q   <= '0;
      prio_q <= 1'b0;
    end else if (accept) begin
      a_q    <= sel_a;
      b_q    <= sel_op ? {~sel_b[31], sel_b[30:0]} : sel_b;
      id_q   <= ID_W'(gnt1);
      prio_q <= ~gnt1;
    end
  end

  // Result capture at the end of EXEC; held through DONE until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= 32'd0;
    end else if (state_q == S_EXEC) begin
      rsp_data_q <= res_data;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb/tb_fpu_addsub_arbiter.sv - directed vector bench for fpu_addsub_arbiter
module tb_fpu_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a, req1_b;
  logic [31:0] dp_a, dp_b, dp_result;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared a-b datapath: exact results for the operand
  // pairs used here, an arbitrary mix otherwise.
  function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (a == 32'h3F80_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    if (a == 32'h40A0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h7F80_0000 && b == 32'h3F80_0000) return 32'h7F80_0000;
    if (a == 32'h3F80_0000 && b == 32'hFF80_0000) return 32'h7F80_0000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  assign dp_result = dp_model(dp_a, dp_b);

  fpu_addsub_arbiter #(.ID_W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_result  (dp_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_dpb;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

`ifdef FPU_ARB_NAN_CHECK_EN
  localparam logic [31:0] INF_RES = 32'h7FC0_0000;
  localparam logic        INF_ERR = 1'b1;
`else
  localparam logic [31:0] INF_RES = 32'h7F80_0000;
  localparam logic        INF_ERR = 1'b0;
`endif

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string s;
    s = $sformatf("v%0d", idx);
    if (v.req) begin
      req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_valid = 1'b1;
    end else begin
      req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_valid = 1'b1;
    end
    rsp_ready = 1'b0;
    #1;
    chk({s, "_ready0"}, 32'(req0_ready), 32'(!v.req));
    chk({s, "_ready1"}, 32'(req1_ready), 32'(v.req));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({s, "_exec_busy"}, 32'(busy), 32'd1);
    chk({s, "_exec_rspv"}, 32'(rsp_valid), 32'd0);
    chk({s, "_dp_a"}, dp_a, v.a);
    chk({s, "_dp_b"}, dp_b, v.exp_dpb);
    @(posedge clk); #1;
    chk({s, "_rspv"}, 32'(rsp_valid), 32'd1);
    chk({s, "_data"}, rsp_data, v.exp_data);
    chk({s, "_id"}, 32'(rsp_id), 32'(v.req));
    chk({s, "_err"}, 32'(rsp_err), 32'(v.exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({s, "_after_rspv"}, 32'(rsp_valid), 32'd0);
    chk({s, "_after_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acc_cyc[$];
    int acc_id[$];
    int rsp_ids[$];
    logic [31:0] rsp_dat[$];
    logic [31:0] held;

    vecs[0] = '{1'b0, 1'b0, 32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h40A0_0000, 32'hC000_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, INF_RES, INF_ERR};
    vecs[4] = '{1'b1, 1'b0, 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, INF_RES, INF_ERR};
    vecs[5] = '{1'b0, 1'b1, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, INF_RES, INF_ERR};

    req0_valid = 1'b0; req0_op = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_dpa", dp_a, 32'd0);
    chk("rst_dpb", dp_b, 32'd0);
    chk("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    do_reset();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Both requesters saturating: alternate grants, accept every 3 cycles.
    do_reset();
    req0_op = 1'b1; req0_a = 32'h40A0_0000; req0_b = 32'hC000_0000;
    req1_op = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && rsp_ids.size() < 4; cyc++) begin
      if (req0_ready && req0_ready === req1_ready) chk("rr_two_ready", 32'd1, 32'd0);
      if (req0_ready && req0_valid) begin acc_cyc.push_back(cyc); acc_id.push_back(0); end
      if (req1_ready && req1_valid) begin acc_cyc.push_back(cyc); acc_id.push_back(1); end
      if (rsp_valid && rsp_ready) begin rsp_ids.push_back(int'(rsp_id)); rsp_dat.push_back(rsp_data); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk("rr_rsp_count", 32'(rsp_ids.size()), 32'd4);
    if (acc_cyc.size() >= 4 && rsp_ids.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr_acc_id%0d", k), 32'(acc_id[k]), 32'(k % 2));
        chk($sformatf("rr_acc_cyc%0d", k), 32'(acc_cyc[k]), 32'(3 * k));
        chk($sformatf("rr_rsp_id%0d", k), 32'(rsp_ids[k]), 32'(k % 2));
        chk($sformatf("rr_rsp_data%0d", k), rsp_dat[k], (k % 2 == 0) ? 32'h4040_0000 : 32'h4000_0000);
      end
    end
    @(posedge clk); #1;

    // Backpressure in DONE for 5 cycles with both valids pending.
    do_reset();
    req0_op = 1'b0; req0_a = 32'h4040_0000; req0_b = 32'h3F80_0000; req0_valid = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    held = 32'h4000_0000;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_rspv%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold_data%0d", k), rsp_data, held);
      chk($sformatf("hold_rdy%0d", k), {30'd0, req1_ready, req0_ready}, 32'd0);
      chk($sformatf("hold_busy%0d", k), 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_rspv", 32'(rsp_valid), 32'd0);

    // Reset while in EXEC discards the operation.
    req1_op = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000; req1_valid = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_dpa", dp_a, 32'd0);
    chk("mrst_dpb", dp_b, 32'd0);
    chk("mrst_data", rsp_data, 32'd0);
    chk("mrst_id", 32'(rsp_id), 32'd0);
    chk("mrst_rspv", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mrst_norsp%0d", k), 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
